// File: rtl/ysyx_22040175_ifu_pkg.sv
// Shared constants and types for the instruction fetch unit.
// The defaults here are what the ifu picks up when no parameters are overridden.
package ysyx_22040175_ifu_pkg;

    localparam int unsigned XLEN_DEFAULT     = 64;
    localparam int unsigned DEPTH_DEFAULT    = 4;
    localparam int unsigned INST_WIDTH       = 32;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDrain  = 2'd1,
        StHalted = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ysyx_22040175_ifu_if.sv
// Fetch-side bundle: memory request/response, decode output, redirect and halt control.
// The master modport is the ifu; the slave modport is memory, decode and execute together.
interface ysyx_22040175_ifu_if #(
    parameter int unsigned XLEN = 64
);
    import ysyx_22040175_ifu_pkg::*;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [XLEN-1:0]       mem_req_addr;
    logic                  mem_resp_valid;
    logic [INST_WIDTH-1:0] mem_resp_data;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [INST_WIDTH-1:0] inst;
    logic [XLEN-1:0]       inst_pc;
    logic                  redirect_valid;
    logic [XLEN-1:0]       redirect_pc;
    logic                  halt;
    logic                  halted;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready,
        input  mem_resp_valid, mem_resp_data,
        output inst_valid, inst, inst_pc,
        input  inst_ready,
        input  redirect_valid, redirect_pc,
        input  halt,
        output halted
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready,
        output mem_resp_valid, mem_resp_data,
        input  inst_valid, inst, inst_pc,
        output inst_ready,
        output redirect_valid, redirect_pc,
        output halt,
        input  halted
    );

endinterface

// File: rtl/ysyx_22040175_ifu_fifo.sv
// Instruction buffer holding fetched words with their PCs.
// Flush wins over push and pop; occupancy comes from the count, never from pointer compare.
module ysyx_22040175_ifu_fifo
    import ysyx_22040175_ifu_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [INST_WIDTH-1:0]  push_inst,
    input  logic [XLEN-1:0]        push_pc,
    input  logic                   pop,
    output logic [INST_WIDTH-1:0]  head_inst,
    output logic [XLEN-1:0]        head_pc,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] Full = (PtrW + 1)'(DEPTH);

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [XLEN-1:0]       pc;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign do_push = push && !flush && (count_q != Full);
    assign do_pop  = pop && !flush && (count_q != '0);

    always_comb begin
        count_d = count_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
        if (flush) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= '{inst: push_inst, pc: push_pc};
        end
    end

    assign head_inst = mem_q[rd_ptr_q].inst;
    assign head_pc   = mem_q[rd_ptr_q].pc;
    assign count     = count_q;

endmodule

// File: rtl/ysyx_22040175_ifu.sv
// Decoupled instruction fetch: credit-limited requests, in-order responses, redirect flush
// with stale-response dropping, and a run/drain/halted stop sequence for ebreak.
module ysyx_22040175_ifu
    import ysyx_22040175_ifu_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEFAULT,
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = DEPTH_DEFAULT
) (
    input logic                 clk,
    input logic                 rst,
    ysyx_22040175_ifu_if.master bus
);
    localparam int unsigned     CntW    = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] ResetPc = RESET_PC[XLEN-1:0];
    localparam logic [CntW:0]   Credits = (CntW + 1)'(DEPTH);

    ifu_state_e            state_q;
    logic                  halted_q;
    logic [XLEN-1:0]       fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]       resp_pc_q, resp_pc_d;
    logic [XLEN-1:0]       redirect_target;
    logic [CntW-1:0]       outstanding_q, outstanding_d;
    logic [CntW-1:0]       drop_q, drop_d;
    logic [CntW-1:0]       count;
    logic                  req_valid, req_fire, resp_push, inst_pop, buf_valid;
    logic [INST_WIDTH-1:0] head_inst;
    logic [XLEN-1:0]       head_pc;

    assign redirect_target = bus.redirect_pc & ~XLEN'(3);

    // Credits cover both buffered entries and in-flight responses, so a response never overflows.
    assign req_valid = !rst && (state_q == StRun) && !bus.redirect_valid &&
                       (({1'b0, outstanding_q} + {1'b0, count}) < Credits);
    assign req_fire  = req_valid && bus.mem_req_ready;
    assign resp_push = bus.mem_resp_valid && !bus.redirect_valid && (drop_q == '0);
    assign buf_valid = (count != '0);
    assign inst_pop  = buf_valid && bus.inst_ready;

    always_comb begin
        outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(bus.mem_resp_valid);

        drop_d = drop_q;
        if (bus.redirect_valid) begin
            drop_d = outstanding_q - CntW'(bus.mem_resp_valid);
        end else if (bus.mem_resp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CntW'(1);
        end

        fetch_pc_d = fetch_pc_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = redirect_target;
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end

        // Requests between redirects are sequential, so the next kept response PC is a counter.
        resp_pc_d = resp_pc_q;
        if (bus.redirect_valid) begin
            resp_pc_d = redirect_target;
        end else if (resp_push) begin
            resp_pc_d = resp_pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= ResetPc;
            resp_pc_q     <= ResetPc;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StRun;
            halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (bus.halt) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (bus.redirect_valid && !bus.halt) begin
                        state_q <= StRun;
                    end else if (outstanding_d == '0) begin
                        state_q  <= StHalted;
                        halted_q <= 1'b1;
                    end
                end
                StHalted: begin
                    if (bus.redirect_valid && !bus.halt) begin
                        state_q  <= StRun;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StRun;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    ysyx_22040175_ifu_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect_valid),
        .push      (resp_push),
        .push_inst (bus.mem_resp_data),
        .push_pc   (resp_pc_q),
        .pop       (inst_pop),
        .head_inst (head_inst),
        .head_pc   (head_pc),
        .count     (count)
    );

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = fetch_pc_q;
    assign bus.inst_valid    = buf_valid;
    assign bus.inst          = buf_valid ? head_inst : '0;
    assign bus.inst_pc       = buf_valid ? head_pc : '0;
    assign bus.halted        = halted_q;

endmodule
